// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// SEQDET_MAX_W bounds the pattern width that len_mask can describe.
package seqdet_pkg;

    localparam int SEQDET_MAX_W = 64;

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } seqdet_state_t;

    // Mask with the low `len` bits set; callers keep the low PAT_W bits.
    function automatic logic [SEQDET_MAX_W-1:0] len_mask(input int unsigned len);
        logic [SEQDET_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < SEQDET_MAX_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module seqdet_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loaded pattern of 1..PAT_W bits,
// overlapping or non-overlapping detection and a saturating match counter.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             detctd,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err,
    output logic             armed
);

    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

    seqdet_state_t state_reg, state_next;

    logic [PAT_W-1:0] pat_reg, pat_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic             ovl_reg, ovl_next;
    logic [PAT_W-1:0] hist_reg, hist_next;
    logic [LEN_W-1:0] fill_reg, fill_next;
    logic             detctd_reg, detctd_next;
    logic             cfg_err_reg, cfg_err_next;
    logic             armed_reg, armed_next;

    logic [SEQDET_MAX_W-1:0] mask_full;
    logic [PAT_W-1:0]        mask;
    logic [PAT_W-1:0]        shift_hist;
    logic [PAT_W-1:0]        bit_eq;
    logic [LEN_W-1:0]        fill_inc;
    logic                    cfg_ok;
    logic                    sampling;
    logic                    match;

    assign mask_full = len_mask(32'(len_reg));
    assign mask      = mask_full[PAT_W-1:0];

    generate
        if (PAT_W < SEQDET_MAX_W) begin : g_mask_rest
            logic unused_mask_hi;
            assign unused_mask_hi = ^mask_full[SEQDET_MAX_W-1:PAT_W];
        end
    endgenerate

    // Bits outside the active length always compare equal.
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = ~mask[gi] | (shift_hist[gi] ~^ pat_reg[gi]);
        end
    endgenerate

    always_comb begin
        cfg_ok     = (pat_len != '0) && (pat_len <= PAT_W_L);
        shift_hist = {hist_reg[PAT_W-2:0], in};
        fill_inc   = (fill_reg == PAT_W_L) ? fill_reg : fill_reg + 1'b1;
        // A configuration load swallows any bit presented with it.
        sampling   = (state_reg == RUN) && in_valid && !cfg_load;
        match      = sampling && (fill_inc >= len_reg) && (&bit_eq);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= UNCFG;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        if (cfg_load) begin
            state_next = cfg_ok ? RUN : UNCFG;
        end
    end

    // FSM: outputs (registered below)
    always_comb begin
        detctd_next  = match;
        cfg_err_next = cfg_load ? !cfg_ok : cfg_err_reg;
        armed_next   = (state_next == RUN);
    end

    always_comb begin
        pat_next  = pat_reg;
        len_next  = len_reg;
        ovl_next  = ovl_reg;
        hist_next = hist_reg;
        fill_next = fill_reg;
        if (cfg_load) begin
            if (cfg_ok) begin
                pat_next  = pattern;
                len_next  = pat_len;
                ovl_next  = overlap;
                hist_next = '0;
                fill_next = '0;
            end
        end else if (match && !ovl_reg) begin
            hist_next = '0;
            fill_next = '0;
        end else if (sampling) begin
            hist_next = shift_hist;
            fill_next = fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg     <= '0;
            len_reg     <= '0;
            ovl_reg     <= 1'b0;
            hist_reg    <= '0;
            fill_reg    <= '0;
            detctd_reg  <= 1'b0;
            cfg_err_reg <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            pat_reg     <= pat_next;
            len_reg     <= len_next;
            ovl_reg     <= ovl_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            detctd_reg  <= detctd_next;
            cfg_err_reg <= cfg_err_next;
            armed_reg   <= armed_next;
        end
    end

    seqdet_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(match),
        .clr(cnt_clr),
        .cnt(match_cnt)
    );

    assign detctd  = detctd_reg;
    assign cfg_err = cfg_err_reg;
    assign armed   = armed_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a default instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation case.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_bit;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       overlap;
    logic       cnt_clr;

    logic       det1, err1, arm1;
    logic [7:0] cnt1;
    logic       det2, err2, arm2;
    logic [1:0] cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
        .overlap(overlap), .cnt_clr(cnt_clr), .detctd(det1),
        .match_cnt(cnt1), .cfg_err(err1), .armed(arm1)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid),
        .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
        .overlap(overlap), .cnt_clr(cnt_clr), .detctd(det2),
        .match_cnt(cnt2), .cfg_err(err2), .armed(arm2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // One clock: inputs change on the falling edge, outputs are read 1 ns after the rising edge.
    task automatic cyc(input logic b, input logic v, input logic ld, input logic clr);
        @(negedge clk);
        in_bit   = b;
        in_valid = v;
        cfg_load = ld;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic config_det(input logic [7:0] p, input logic [3:0] l, input logic o);
        pattern = p;
        pat_len = l;
        overlap = o;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clear_cnt();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Bit i of `bits` is the (i+1)-th bit sent; bit i of `exp_det` is detctd after it.
    task automatic send_stream(input string tag, input logic [15:0] bits, input int n,
                               input logic [15:0] exp_det);
        for (int i = 0; i < n; i++) begin
            cyc(bits[i], 1'b1, 1'b0, 1'b0);
            chk($sformatf("%s_b%0d", tag, i + 1), 32'(det1), 32'(exp_det[i]));
        end
    endtask

    initial begin
        rst = 1'b0; in_bit = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        pattern = '0; pat_len = '0; overlap = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_det", 32'(det1), 0);
        chk("rst_cnt", 32'(cnt1), 0);
        chk("rst_err", 32'(err1), 0);
        chk("rst_armed", 32'(arm1), 0);
        @(negedge clk);
        rst = 1'b1;

        // Unconfigured: bits are ignored.
        send_stream("uncfg", 16'h0001, 2, 16'h0000);
        chk("uncfg_armed", 32'(arm1), 0);

        // Pattern 1111, overlap.
        config_det(8'b0000_1111, 4'd4, 1'b1);
        chk("cfg1_armed", 32'(arm1), 1);
        chk("cfg1_err", 32'(err1), 0);
        send_stream("p1111", 16'(11'b11110111101), 11, 16'(11'b10000100000));
        chk("p1111_cnt", 32'(cnt1), 2);

        // Pattern 1011 with junk above the active length.
        config_det(8'b1111_1011, 4'd4, 1'b1);
        clear_cnt();
        chk("clr_cnt", 32'(cnt1), 0);
        send_stream("p1011", 16'(11'b11110111101), 11, 16'(11'b00100001000));
        chk("p1011_cnt", 32'(cnt1), 2);

        // Six ones, overlap vs non-overlap.
        config_det(8'b0000_1111, 4'd4, 1'b1);
        clear_cnt();
        send_stream("ovl1", 16'h003F, 6, 16'h0038);
        chk("ovl1_cnt", 32'(cnt1), 3);
        config_det(8'b0000_1111, 4'd4, 1'b0);
        clear_cnt();
        send_stream("ovl0", 16'h003F, 6, 16'h0008);
        chk("ovl0_cnt", 32'(cnt1), 1);

        // Valid gaps inside a pattern.
        config_det(8'b0000_1011, 4'd4, 1'b1);
        clear_cnt();
        cyc(1'b1, 1'b1, 1'b0, 1'b0); chk("gap_b1", 32'(det1), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0); chk("gap_b2", 32'(det1), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("gap_idle%0d", i), 32'(det1), 0);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0); chk("gap_b3", 32'(det1), 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0); chk("gap_b4", 32'(det1), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("gap_after", 32'(det1), 0);
        chk("gap_cnt", 32'(cnt1), 1);

        // Illegal lengths.
        config_det(8'b0000_1011, 4'd0, 1'b1);
        chk("len0_err", 32'(err1), 1);
        chk("len0_armed", 32'(arm1), 0);
        send_stream("len0", 16'h000D, 4, 16'h0000);
        chk("len0_cnt", 32'(cnt1), 1);
        config_det(8'b0000_1011, 4'd9, 1'b1);
        chk("len9_err", 32'(err1), 1);
        chk("len9_armed", 32'(arm1), 0);

        // Full-width pattern A5 (first bit = pattern[7]).
        config_det(8'hA5, 4'd8, 1'b0);
        chk("len8_err", 32'(err1), 0);
        chk("len8_armed", 32'(arm1), 1);
        send_stream("len8", 16'h00A5, 8, 16'h0080);
        chk("len8_cnt", 32'(cnt1), 2);

        // Saturation on the CNT_W=2 instance; load beats a bit in the same cycle.
        pattern = 8'h01; pat_len = 4'd1; overlap = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("ldprio_det", 32'(det2), 0);
        clear_cnt();
        chk("sat_start", 32'(cnt2), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("sat_det%0d", i + 1), 32'(det2), 1);
            chk($sformatf("sat_cnt%0d", i + 1), 32'(cnt2), (i < 3) ? i + 1 : 3);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_vs_match_det", 32'(det2), 1);
        chk("clr_vs_match_cnt", 32'(cnt2), 0);

        // Reset mid-pattern.
        config_det(8'b0000_1011, 4'd4, 1'b0);
        clear_cnt();
        send_stream("pre_rst", 16'h000D, 4, 16'h0008);
        chk("pre_rst_cnt", 32'(cnt1), 1);
        send_stream("part", 16'h0005, 3, 16'h0000);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_det", 32'(det1), 0);
        chk("arst_cnt", 32'(cnt1), 0);
        chk("arst_armed", 32'(arm1), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_det", 32'(det1), 0);
        chk("post_rst_armed", 32'(arm1), 0);
        chk("post_rst_cnt", 32'(cnt1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
